// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux scan serializer.
// Used by the controller and its bit-period strobe generator.
package mux_scan_pkg;

    localparam int SEL_W  = 3;
    localparam int DATA_W = 8;
    localparam logic [SEL_W-1:0] SEL_LAST = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Appends one sampled bit to the capture word, MSB first.
    function automatic logic [DATA_W-1:0] shift_in(
        input logic [DATA_W-1:0] cap,
        input logic              b
    );
        return {cap[DATA_W-2:0], b};
    endfunction

endpackage

// File: rtl/mux_scan_serializer_bit_tick_gen.sv
// Bit-period strobe: tick is high in the last cycle of each TICK_DIV-cycle period.
// clr holds the period counter at zero while no frame is shifting.
module bit_tick_gen #(
    parameter int TICK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Period counter, restarts after every strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr || tick) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign tick = (cnt_r == CNT_LAST);

endmodule

// File: rtl/mux_scan_serializer.sv
// Drives a byte onto an external 8:1 mux, walks the select 0..7 and samples the
// mux output into an MSB-first stream; the reassembled byte exposes mux/wiring faults.
module mux_scan_serializer
    import mux_scan_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [SEL_W-1:0]  mux_s,
    output logic [DATA_W-1:0] mux_d,
    input  logic              mux_y,
    output logic              bit_valid,
    output logic              bit_out,
    output logic              frame_done,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_err,
    output logic              busy
);

    state_t            state_r;
    logic [DATA_W-1:0] capture_r;
    logic [DATA_W-1:0] cap_next_s;
    logic              tick_s;
    logic              clr_s;

    assign clr_s      = (state_r != SHIFT);
    assign cap_next_s = shift_in(capture_r, mux_y);
    assign in_ready   = (state_r == IDLE);
    assign busy       = (state_r != IDLE);

    bit_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr_s),
        .tick (tick_s)
    );

    // Frame FSM; the frame result is registered on the final sampling edge so
    // frame_done lines up with the last bit_valid in the single DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            capture_r  <= {DATA_W{1'b0}};
            mux_s      <= {SEL_W{1'b0}};
            mux_d      <= {DATA_W{1'b0}};
            bit_valid  <= 1'b0;
            bit_out    <= 1'b0;
            frame_done <= 1'b0;
            frame_data <= {DATA_W{1'b0}};
            frame_err  <= 1'b0;
        end else begin
            bit_valid  <= 1'b0;
            frame_done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        mux_d     <= in_data;
                        mux_s     <= {SEL_W{1'b0}};
                        capture_r <= {DATA_W{1'b0}};
                        state_r   <= SHIFT;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                SHIFT: begin
                    if (tick_s) begin
                        capture_r <= cap_next_s;
                        bit_out   <= mux_y;
                        bit_valid <= 1'b1;
                        if (mux_s == SEL_LAST) begin
                            state_r    <= DONE;
                            frame_done <= 1'b1;
                            frame_data <= cap_next_s;
                            frame_err  <= (cap_next_s != mux_d);
                        end else begin
                            mux_s <= mux_s + 3'd1;
                        end
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    mux_s   <= {SEL_W{1'b0}};
                end
                default: begin
                    state_r <= IDLE;
                    mux_s   <= {SEL_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_serializer.sv
// Directed bench: two serializers (TICK_DIV=1 and 3) each wrapped around an
// 8:1 mux model; the TICK_DIV=1 mux can have select 2 stuck at zero.
module tb_mux_scan_serializer;

    logic clk = 1'b0;
    logic rst;
    logic fault_en;

    always #5 clk = ~clk;

    logic       in_valid1, in_ready1, mux_y1, bit_valid1, bit_out1;
    logic       frame_done1, frame_err1, busy1;
    logic [2:0] mux_s1;
    logic [7:0] in_data1, mux_d1, frame_data1;

    logic       in_valid3, in_ready3, mux_y3, bit_valid3, bit_out3;
    logic       frame_done3, frame_err3, busy3;
    logic [2:0] mux_s3;
    logic [7:0] in_data3, mux_d3, frame_data3;

    int checks = 0;
    int failures = 0;

    // 8:1 mux: select 0 routes d[7], select 7 routes d[0].
    assign mux_y1 = (fault_en && mux_s1 == 3'd2) ? 1'b0 : mux_d1[3'd7 - mux_s1];
    assign mux_y3 = mux_d3[3'd7 - mux_s3];

    mux_scan_serializer #(.TICK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .mux_s(mux_s1), .mux_d(mux_d1), .mux_y(mux_y1),
        .bit_valid(bit_valid1), .bit_out(bit_out1), .frame_done(frame_done1),
        .frame_data(frame_data1), .frame_err(frame_err1), .busy(busy1)
    );

    mux_scan_serializer #(.TICK_DIV(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid3), .in_data(in_data3),
        .in_ready(in_ready3), .mux_s(mux_s3), .mux_d(mux_d3), .mux_y(mux_y3),
        .bit_valid(bit_valid3), .bit_out(bit_out3), .frame_done(frame_done3),
        .frame_data(frame_data3), .frame_err(frame_err3), .busy(busy3)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One TICK_DIV=1 frame; called at the negedge where the word is offered (cycle 0).
    task automatic run_frame1(input logic [7:0] data, input logic [7:0] exp_data,
                              input logic exp_err, input logic next_valid,
                              input logic [7:0] next_data, input logic poke);
        int exp_s;
        check_val("ready_c0", 32'(in_ready1), 32'd1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            exp_s = (c <= 8) ? c - 1 : ((c == 9) ? 7 : 0);
            check_val("bit_valid", 32'(bit_valid1), 32'(c >= 2 && c <= 9));
            if (c >= 2 && c <= 9) check_val("bit_out", 32'(bit_out1), 32'(exp_data[9-c]));
            check_val("frame_done", 32'(frame_done1), 32'(c == 9));
            check_val("in_ready", 32'(in_ready1), 32'(c == 10));
            check_val("busy", 32'(busy1), 32'(c <= 9));
            check_val("mux_s", 32'(mux_s1), 32'(exp_s));
            if (c <= 9) check_val("mux_d", 32'(mux_d1), 32'(data));
            if (c == 9) begin
                check_val("frame_data", 32'(frame_data1), 32'(exp_data));
                check_val("frame_err", 32'(frame_err1), 32'(exp_err));
            end
            if (c == 1) begin
                in_valid1 = next_valid;
                in_data1  = next_data;
            end
            if (poke && c == 4) begin
                in_valid1 = 1'b1;
                in_data1  = 8'h55;
            end
            if (poke && c == 5) begin
                in_valid1 = next_valid;
                in_data1  = next_data;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        fault_en = 1'b0;
        in_valid1 = 1'b0; in_data1 = 8'h00;
        in_valid3 = 1'b0; in_data3 = 8'h00;
        repeat (3) @(negedge clk);
        check_val("rst_mux_s", 32'(mux_s1), 32'd0);
        check_val("rst_mux_d", 32'(mux_d1), 32'd0);
        check_val("rst_bit_valid", 32'(bit_valid1), 32'd0);
        check_val("rst_frame_done", 32'(frame_done1), 32'd0);
        check_val("rst_in_ready", 32'(in_ready1), 32'd1);
        check_val("rst_busy3", 32'(busy3), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // TICK_DIV=3, 8'h3C
        in_valid3 = 1'b1; in_data3 = 8'h3C;
        for (int c = 1; c <= 26; c++) begin
            @(negedge clk);
            if (c == 1) in_valid3 = 1'b0;
            check_val("t3_bit_valid", 32'(bit_valid3), 32'(c >= 4 && c <= 25 && (c - 1) % 3 == 0));
            if (c >= 4 && c <= 25 && (c - 1) % 3 == 0)
                check_val("t3_bit_out", 32'(bit_out3), 32'(in_data3[8 - (c - 1) / 3]));
            check_val("t3_mux_s", 32'(mux_s3), (c <= 24) ? 32'((c - 1) / 3) : ((c == 25) ? 32'd7 : 32'd0));
            check_val("t3_frame_done", 32'(frame_done3), 32'(c == 25));
            check_val("t3_in_ready", 32'(in_ready3), 32'(c == 26));
            if (c == 25) begin
                check_val("t3_frame_data", 32'(frame_data3), 32'h3C);
                check_val("t3_frame_err", 32'(frame_err3), 32'd0);
            end
        end

        // TICK_DIV=1 basic frame
        in_valid1 = 1'b1; in_data1 = 8'hA5;
        run_frame1(8'hA5, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);

        // word offered while busy must be ignored
        in_valid1 = 1'b1; in_data1 = 8'h96;
        run_frame1(8'h96, 8'h96, 1'b0, 1'b0, 8'h00, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_val("idle_ready", 32'(in_ready1), 32'd1);
            check_val("idle_bit_valid", 32'(bit_valid1), 32'd0);
            check_val("idle_frame_done", 32'(frame_done1), 32'd0);
            check_val("idle_mux_d", 32'(mux_d1), 32'h96);
        end

        // back-to-back with in_valid held
        in_valid1 = 1'b1; in_data1 = 8'hFF;
        run_frame1(8'hFF, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0);
        run_frame1(8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);

        // select 2 stuck at zero
        fault_en = 1'b1;
        in_valid1 = 1'b1; in_data1 = 8'hFF;
        run_frame1(8'hFF, 8'hDF, 1'b1, 1'b0, 8'h00, 1'b0);
        fault_en = 1'b0;

        // reset after the 4th bit
        in_valid1 = 1'b1; in_data1 = 8'hFF;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) in_valid1 = 1'b0;
        end
        check_val("pre_rst_bit_valid", 32'(bit_valid1), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_mux_s", 32'(mux_s1), 32'd0);
        check_val("mid_rst_mux_d", 32'(mux_d1), 32'd0);
        check_val("mid_rst_bit_valid", 32'(bit_valid1), 32'd0);
        check_val("mid_rst_bit_out", 32'(bit_out1), 32'd0);
        check_val("mid_rst_frame_done", 32'(frame_done1), 32'd0);
        check_val("mid_rst_frame_data", 32'(frame_data1), 32'd0);
        check_val("mid_rst_frame_err", 32'(frame_err1), 32'd0);
        check_val("mid_rst_busy", 32'(busy1), 32'd0);
        check_val("mid_rst_in_ready", 32'(in_ready1), 32'd1);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_val("post_rst_frame_done", 32'(frame_done1), 32'd0);
            check_val("post_rst_bit_valid", 32'(bit_valid1), 32'd0);
        end
        in_valid1 = 1'b1; in_data1 = 8'h81;
        run_frame1(8'h81, 8'h81, 1'b0, 1'b0, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_scan_serializer.md
Name: mux_scan_serializer

Overview:
- Controller that sits directly around the team's 8-to-1 multiplexer.
- Accepts an 8-bit word over a valid/ready handshake and drives it onto the mux data inputs.
- Steps the mux select from 3'b000 to 3'b111 and samples the mux output once per bit period. This produces an MSB-first serial stream.
- Because select 3'b000 routes d[7] and 3'b111 routes d[0], the captured bits reassemble into the original byte. A mismatch flags a wiring or mux fault.

Parameters:
- TICK_DIV, 1, clock cycles per bit period (≥1). mux_s is held stable for TICK_DIV cycles per bit.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input word valid
- in_data  in  8  word to serialize
- in_ready  out  1  block can accept a word
- mux_s  out  3  select driven to the external mux
- mux_d  out  8  data vector driven to the external mux
- mux_y  in  1  mux output (combinational from mux_s/mux_d)
- bit_valid  out  1  one-cycle pulse per serialized bit
- bit_out  out  1  serialized bit, valid when bit_valid=1
- frame_done  out  1  one-cycle pulse, frame complete
- frame_data  out  8  reassembled byte, valid when frame_done=1
- frame_err  out  1  frame_data != latched word, valid when frame_done=1
- busy  out  1  state != IDLE

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst), fixed as stated.
- Reset values: state=IDLE, mux_s=0, mux_d=0, bit_valid=0, bit_out=0, frame_done=0, frame_data=0, frame_err=0, capture register=0, tick counter=0.
- in_ready = (state==IDLE), combinational from state only.
- IDLE:
  - On in_valid&&in_ready at edge E0: mux_d<=in_data, mux_s<=0, tick counter<=0, capture<=0, state<=SHIFT.
- SHIFT:
  - The tick counter counts 0..TICK_DIV-1. A bit is sampled on the edge where the counter equals TICK_DIV-1.
  - At the sampling edge: capture<={capture[6:0],mux_y}; bit_out<=mux_y; bit_valid<=1 for the next cycle only.
  - After sampling, if mux_s==7: state<=DONE. Otherwise mux_s<=mux_s+1 and the counter<=0.
  - mux_s never wraps inside a frame.
- DONE (exactly one cycle):
  - frame_done=1.
  - frame_data = capture, including the final bit.
  - frame_err = (capture != mux_d).
  - Then state<=IDLE; mux_s returns to 0 and mux_d holds its value.
- Timing with TICK_DIV=1 and accept at E0:
  - bit_valid is high in cycles 2..9.
  - The last bit_valid coincides with frame_done in cycle 9.
  - in_ready is high again in cycle 10.
  - General frame length: 8*TICK_DIV+2 cycles from accept to in_ready.
- in_valid while busy: ignored. The word is not latched and in_ready stays 0; the upstream block must hold the word.
- Reset mid-frame: abort immediately to reset values. No frame_done or bit_valid is issued for the partial frame.
- bit_valid and frame_done are registered outputs; neither is ever asserted while in IDLE.
- Arithmetic: mux_s is a 3-bit increment. The tick counter is $clog2(TICK_DIV)+1 bits wide; for TICK_DIV=1 it is constant 0.

Decomposition:
- Package mux_scan_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - SEL_W=3, DATA_W=8, SEL_LAST=3'b111
- Sub-module bit_tick_gen (parameter TICK_DIV; ports clk, rst, clr, tick): produces the sampling strobe.
- The top module instantiates bit_tick_gen. The 8-to-1 mux itself is instantiated only in the testbench and the system top.

Test Plan:
- TICK_DIV=1, real mux attached, send 8'hA5 → bit_out sequence 1,0,1,0,0,1,0,1 in cycles 2..9; frame_done in cycle 9 with frame_data=8'hA5, frame_err=0.
- TICK_DIV=3, send 8'h3C → each mux_s value held 3 cycles; 8 bit_valid pulses spaced 3 cycles apart; frame_data=8'h3C; in_ready returns 26 cycles after accept.
- Back-to-back: in_valid held high with 8'hFF then 8'h00 → second word accepted only in the cycle in_ready rises; 8'hFF is not overwritten; two frame_done pulses with the correct data.
- Fault injection: bench forces mux_y=0 while mux_s==3'b010, send 8'hFF → frame_data=8'hDF, frame_err=1.
- Reset mid-frame: assert rst after the 4th bit_valid → next cycle all outputs at reset values; no frame_done; next word 8'h81 serializes correctly.
- in_valid pulsed while busy (8'h55 during a frame) → ignored; no extra frame produced.
